// File: rtl/gpu_row_pkg.sv
// Shared definitions for the GPU row collector and the row disaggregator.
package gpu_row_pkg;

  localparam int LANES  = 16;
  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  // Mask used by the disaggregator's mask-and-merge: (row & HIGH_MASK) | data.
  localparam logic [WORD_W-1:0] HIGH_MASK = 16'hff00;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  // One row: LANES words, lane i at bits [WORD_W*i +: WORD_W] when flattened.
  typedef logic [LANES-1:0][WORD_W-1:0] row_t;

endpackage

// File: rtl/gpu_row_capture_slot.sv
// Single-entry valid/ready holding register for the row-buffer snapshot.
// Accepts one snapshot while empty, holds it until cleared by the consumer.
module gpu_row_capture_slot #(
  parameter int DATA_W = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clear,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Ready only while empty; clear and capture cannot coincide because
  // clear is only raised while the slot is full.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clear) begin
      full_d = 1'b0;
      data_d = '0;
    end else if (in_valid && !full_q) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  // Slot state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign in_ready = !full_q;
  assign full     = full_q;
  assign data     = data_q;

endmodule

// File: rtl/gpu_row_byte_collector.sv
// Gathers a serial byte stream into a row of zero-extended words and pairs it
// with a captured row-buffer snapshot on one output.
//
// Handshakes: every interface transfers on a rising edge where valid and ready
// are both high. Ready never depends combinationally on valid, and once a
// valid is raised by this block its payload holds until accepted.
module gpu_row_byte_collector #(
  parameter int LANES  = gpu_row_pkg::LANES,
  parameter int WORD_W = gpu_row_pkg::WORD_W,
  parameter int BYTE_W = gpu_row_pkg::BYTE_W,
  localparam int CNT_W = $clog2(LANES + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BYTE_W-1:0]         in_byte,
  input  logic                      in_last,
  input  logic                      rb_valid,
  output logic                      rb_ready,
  input  logic [LANES*WORD_W-1:0]   rb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*WORD_W-1:0]   out_data,
  output logic [LANES*WORD_W-1:0]   out_row,
  output logic [CNT_W-1:0]          out_count,
  output gpu_row_pkg::state_t       dbg_state
);

  import gpu_row_pkg::*;

  localparam int IDX_W = $clog2(LANES);
  localparam int PAD_W = WORD_W - BYTE_W;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [LANES-1:0][WORD_W-1:0]   lanes_q, lanes_d;

  logic                           rb_full;
  logic [LANES*WORD_W-1:0]        rb_snap;
  logic                           emit;

  assign emit = out_valid && out_ready;

  // Snapshot slot runs independently of the byte FSM; emptied on emit.
  gpu_row_capture_slot #(
    .DATA_W (LANES*WORD_W)
  ) u_slot (
    .clock    (clock),
    .reset    (reset),
    .in_valid (rb_valid),
    .in_ready (rb_ready),
    .in_data  (rb_data),
    .clear    (emit),
    .full     (rb_full),
    .data     (rb_snap)
  );

  // Next-state: emit resets the row; in FILL each accepted byte lands in
  // lane[cnt]. Lanes beyond the final count stay zero from the last clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lanes_d = lanes_q;
    if (emit) begin
      state_d = FILL;
      cnt_d   = '0;
      lanes_d = '0;
    end else if (state_q == FILL && in_valid) begin
      lanes_d[cnt_q[IDX_W-1:0]] = {{PAD_W{1'b0}}, in_byte};
      cnt_d = cnt_q + CNT_W'(1);
      if (in_last || cnt_q == CNT_W'(LANES - 1)) begin
        state_d = FULL;
      end
    end
  end

  // FSM, counter and lane registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lanes_q <= lanes_d;
    end
  end

  // All outputs come straight from registers.
  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == FULL) && rb_full;
  assign out_data  = lanes_q;
  assign out_row   = rb_snap;
  assign out_count = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gpu_row_byte_collector.sv
// Directed bench for gpu_row_byte_collector: table of row vectors plus
// hand-written stall, no-bypass and asynchronous-reset sequences.
module tb_gpu_row_byte_collector;

  localparam int ROW_W   = 256;
  localparam int TIMEOUT = 64;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_byte;
  logic              in_last;
  logic              rb_valid;
  logic              rb_ready;
  logic [ROW_W-1:0]  rb_data;
  logic              out_valid;
  logic              out_ready;
  logic [ROW_W-1:0]  out_data;
  logic [ROW_W-1:0]  out_row;
  logic [4:0]        out_count;
  gpu_row_pkg::state_t dbg_state;

  int n_cmp;
  int n_err;

  logic [ROW_W-1:0] exp_data_q[$];
  logic [ROW_W-1:0] exp_row_q[$];
  logic [4:0]       exp_cnt_q[$];

  typedef struct {
    int         nbytes;
    logic [7:0] seed;
    logic [7:0] step;
    bit         last;
    bit         snap_first;
    logic [7:0] snap_hi;
    logic [4:0] exp_count;
  } vec_t;

  vec_t vecs[5];

  gpu_row_byte_collector dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .in_last   (in_last),
    .rb_valid  (rb_valid),
    .rb_ready  (rb_ready),
    .rb_data   (rb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_count (out_count),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [ROW_W-1:0] act,
                       input logic [ROW_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out after %0d cycles", name, TIMEOUT);
  endtask

  // Expected lane image: byte i = seed + i*step, zero-extended, first n lanes.
  function automatic logic [ROW_W-1:0] build_data(input logic [7:0] seed,
                                                  input logic [7:0] step,
                                                  input int n);
    logic [ROW_W-1:0] r;
    logic [7:0] b;
    r = '0;
    b = seed;
    for (int i = 0; i < n; i++) begin
      r[16*i +: 16] = {8'h00, b};
      b = b + step;
    end
    return r;
  endfunction

  // Snapshot image: lane i = {hi, i}.
  function automatic logic [ROW_W-1:0] build_row(input logic [7:0] hi);
    logic [ROW_W-1:0] r;
    logic [7:0] idx;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      idx = 8'(i);
      r[16*i +: 16] = {hi, idx};
    end
    return r;
  endfunction

  // Driver tasks (called at a negedge, return at a negedge)
  task automatic send_byte(input logic [7:0] b, input logic last);
    int t;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    t = 0;
    while (!in_ready && t < TIMEOUT) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) timeout_fail("in_ready_wait");
    else begin
      @(posedge clock);
      @(negedge clock);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_snap(input logic [ROW_W-1:0] d);
    int t;
    rb_valid = 1'b1;
    rb_data  = d;
    t = 0;
    while (!rb_ready && t < TIMEOUT) begin
      @(negedge clock);
      t++;
    end
    if (!rb_ready) timeout_fail("rb_ready_wait");
    else begin
      @(posedge clock);
      @(negedge clock);
    end
    rb_valid = 1'b0;
  endtask

  // Scoreboard: pop expected row and compare, then complete the handshake.
  task automatic take_row(input string tag);
    int t;
    logic [ROW_W-1:0] ed, er;
    logic [4:0] ec;
    t = 0;
    while (!out_valid && t < TIMEOUT) begin
      @(negedge clock);
      t++;
    end
    if (exp_data_q.size() == 0) begin
      timeout_fail({tag, "_no_expected"});
      return;
    end
    ed = exp_data_q.pop_front();
    er = exp_row_q.pop_front();
    ec = exp_cnt_q.pop_front();
    if (!out_valid) begin
      timeout_fail({tag, "_out_valid_wait"});
      return;
    end
    check({tag, "_out_data"},  out_data, ed);
    check({tag, "_out_row"},   out_row, er);
    check({tag, "_out_count"}, ROW_W'(out_count), ROW_W'(ec));
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, ROW_W'(out_valid), ROW_W'(0));
    check({tag, "_count_clear"}, ROW_W'(out_count), ROW_W'(0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  ROW_W'(in_ready), ROW_W'(1));
    check({tag, "_rb_ready"},  ROW_W'(rb_ready), ROW_W'(1));
    check({tag, "_out_valid"}, ROW_W'(out_valid), ROW_W'(0));
    check({tag, "_out_count"}, ROW_W'(out_count), ROW_W'(0));
    check({tag, "_out_data"},  out_data, '0);
    check({tag, "_out_row"},   out_row, '0);
    check({tag, "_state"},     ROW_W'(dbg_state), ROW_W'(gpu_row_pkg::FILL));
  endtask

  initial begin
    logic [ROW_W-1:0] stall_data, stall_row;
    n_cmp = 0;
    n_err = 0;

    vecs[0] = '{16, 8'h00, 8'h01, 1'b0, 1'b1, 8'hAB, 5'd16};
    vecs[1] = '{3,  8'h11, 8'h11, 1'b1, 1'b1, 8'h5A, 5'd3};
    vecs[2] = '{16, 8'hF0, 8'h01, 1'b0, 1'b0, 8'hC3, 5'd16};
    vecs[3] = '{16, 8'h80, 8'h03, 1'b1, 1'b0, 8'h12, 5'd16};
    vecs[4] = '{1,  8'hFF, 8'h00, 1'b1, 1'b1, 8'hE7, 5'd1};

    in_valid  = 1'b0;
    in_byte   = '0;
    in_last   = 1'b0;
    rb_valid  = 1'b0;
    rb_data   = '0;
    out_ready = 1'b0;
    reset     = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("post_release");

    // Table-driven rows
    for (int v = 0; v < 5; v++) begin
      logic [7:0] b;
      exp_data_q.push_back(build_data(vecs[v].seed, vecs[v].step, int'(vecs[v].exp_count)));
      exp_row_q.push_back(build_row(vecs[v].snap_hi));
      exp_cnt_q.push_back(vecs[v].exp_count);
      if (vecs[v].snap_first) send_snap(build_row(vecs[v].snap_hi));
      b = vecs[v].seed;
      for (int i = 0; i < vecs[v].nbytes; i++) begin
        send_byte(b, vecs[v].last && (i == vecs[v].nbytes - 1));
        b = b + vecs[v].step;
      end
      if (vecs[v].snap_first) begin
        check($sformatf("v%0d_latency_valid", v), ROW_W'(out_valid), ROW_W'(1));
      end else begin
        repeat (2) begin
          check($sformatf("v%0d_wait_valid", v), ROW_W'(out_valid), ROW_W'(0));
          check($sformatf("v%0d_wait_in_ready", v), ROW_W'(in_ready), ROW_W'(0));
          @(negedge clock);
        end
        send_snap(build_row(vecs[v].snap_hi));
        check($sformatf("v%0d_after_capture_valid", v), ROW_W'(out_valid), ROW_W'(1));
      end
      take_row($sformatf("v%0d", v));
    end

    // Stall with out_ready low, offers held on both inputs
    stall_data = build_data(8'hA0, 8'h01, 4);
    stall_row  = build_row(8'h3C);
    send_snap(stall_row);
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), i == 3);
    in_valid = 1'b1;
    in_byte  = 8'h55;
    rb_valid = 1'b1;
    rb_data  = build_row(8'h66);
    for (int c = 0; c < 10; c++) begin
      check("stall_out_valid", ROW_W'(out_valid), ROW_W'(1));
      check("stall_out_data",  out_data, stall_data);
      check("stall_out_row",   out_row, stall_row);
      check("stall_out_count", ROW_W'(out_count), ROW_W'(4));
      check("stall_in_ready",  ROW_W'(in_ready), ROW_W'(0));
      check("stall_rb_ready",  ROW_W'(rb_ready), ROW_W'(0));
      @(negedge clock);
    end
    // Emit cycle: new byte and snapshot offered, must not be taken yet
    out_ready = 1'b1;
    in_byte   = 8'h77;
    in_last   = 1'b0;
    rb_data   = build_row(8'h99);
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    check("nobypass_out_valid", ROW_W'(out_valid), ROW_W'(0));
    check("nobypass_count",     ROW_W'(out_count), ROW_W'(0));
    check("nobypass_data",      out_data, '0);
    check("nobypass_in_ready",  ROW_W'(in_ready), ROW_W'(1));
    check("nobypass_rb_ready",  ROW_W'(rb_ready), ROW_W'(1));
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    rb_valid = 1'b0;
    check("next_row_count",    ROW_W'(out_count), ROW_W'(1));
    check("next_row_lane0",    out_data, build_data(8'h77, 8'h11, 1));
    check("next_row_rb_ready", ROW_W'(rb_ready), ROW_W'(0));
    exp_data_q.push_back(build_data(8'h77, 8'h11, 2));
    exp_row_q.push_back(build_row(8'h99));
    exp_cnt_q.push_back(5'd2);
    send_byte(8'h88, 1'b1);
    take_row("after_stall");

    // Asynchronous reset mid-row
    send_snap(build_row(8'h44));
    for (int i = 0; i < 7; i++) send_byte(8'h30 + 8'(i), 1'b0);
    check("pre_reset_count", ROW_W'(out_count), ROW_W'(7));
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    exp_data_q.push_back(build_data(8'hC1, 8'h01, 2));
    exp_row_q.push_back(build_row(8'h21));
    exp_cnt_q.push_back(5'd2);
    send_byte(8'hC1, 1'b0);
    check("post_reset_lane0", out_data, build_data(8'hC1, 8'h01, 1));
    send_byte(8'hC2, 1'b1);
    send_snap(build_row(8'h21));
    take_row("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
